// File: rtl/i2c_arbiter.sv
// Two-requester round-robin front end for a single I2C master: grants one requester,
// issues its command, retries on NACK, enforces a per-attempt timeout, and reports done/err.
module i2c_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1023,
  parameter int          RETRIES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_wdata,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_nack,
  input  logic [7:0]  m_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: req is a level and gnt holds until done; m_start is a one-cycle
  // strobe issued only while m_busy=0; m_nack/m_rdata are qualified by m_done,
  // which is accepted only in WAIT and ignored everywhere else.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] RETRY_MAX = 3'(RETRIES);

  state_t      r_state, w_state_nxt;
  logic        r_ptr, r_win;
  logic [1:0]  r_gnt, r_done;
  logic        r_err, r_m_start, r_rw;
  logic [6:0]  r_addr;
  logic [7:0]  r_wdata, r_rdata;
  logic [15:0] r_tcnt;
  logic [2:0]  r_retry;

  logic        w_win, w_issue, w_finish, w_fail, w_retry;
  logic [15:0] w_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_win       = req[r_ptr] ? r_ptr : ~r_ptr;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    w_fail      = 1'b0;
    w_retry     = 1'b0;
    w_cnt_nxt   = r_tcnt + 16'd1;
    case (r_state)
      IDLE: if (|req) w_state_nxt = ISSUE;
      ISSUE: begin
        if (!m_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A completion in the same cycle as the timeout wins over the timeout.
        if (m_done) begin
          if (!m_nack) begin
            w_finish    = 1'b1;
            w_state_nxt = RESP;
          end else if (r_retry < RETRY_MAX) begin
            w_retry     = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_finish    = 1'b1;
            w_fail      = 1'b1;
            w_state_nxt = RESP;
          end
        end else if (w_cnt_nxt == TIMEOUT) begin
          w_finish    = 1'b1;
          w_fail      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_win     <= 1'b0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
      r_m_start <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= 7'd0;
      r_wdata   <= 8'd0;
      r_rdata   <= 8'd0;
      r_tcnt    <= 16'd0;
      r_retry   <= 3'd0;
    end else begin
      r_m_start <= w_issue;
      r_done    <= w_finish ? r_gnt : 2'b00;
      r_err     <= w_finish & w_fail;
      if (r_state == IDLE && |req) begin
        r_win   <= w_win;
        r_gnt   <= w_win ? 2'b10 : 2'b01;
        r_addr  <= w_win ? req_addr[13:7] : req_addr[6:0];
        r_rw    <= req_rw[w_win];
        r_wdata <= w_win ? req_wdata[15:8] : req_wdata[7:0];
        r_retry <= 3'd0;
      end
      if (w_issue)              r_tcnt <= 16'd0;
      else if (r_state == WAIT) r_tcnt <= w_cnt_nxt;
      if (w_retry) r_retry <= r_retry + 3'd1;
      if (w_finish && !w_fail && r_rw) r_rdata <= m_rdata;
      if (r_state == RESP) begin
        r_ptr <= ~r_win;
        r_gnt <= 2'b00;
      end
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign m_start   = r_m_start;
  assign m_addr    = r_addr;
  assign m_rw      = r_rw;
  assign m_wdata   = r_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: a small master responder, a done/err scoreboard
// fed from an expected queue, and hand-computed checks on grants, strobes and data.
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [13:0] req_addr = 14'd0;
  logic [1:0]  req_rw = 2'b00;
  logic [15:0] req_wdata = 16'd0;
  logic [1:0]  gnt, done, dbg_state;
  logic        err, m_start, m_rw;
  logic [7:0]  rdata, m_wdata;
  logic [6:0]  m_addr;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_nack = 1'b0;
  logic [7:0]  m_rdata = 8'd0;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cnt = 0;
  logic [2:0]  exp_q[$];
  logic [1:0]  cap_gnt;
  logic [6:0]  cap_addr;
  logic        cap_rw;
  logic [7:0]  cap_wdata;

  i2c_arbiter #(.TIMEOUT(16'd1023), .RETRIES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard: every done pulse must match the next expected {err, done}
  always @(negedge clk) begin
    if (m_start) start_cnt++;
    if (!rst && done != 2'b00) begin
      if (exp_q.size() == 0) check_eq("unexp_done", {30'd0, done}, 32'd0);
      else check_eq("sb_done", {29'd0, err, done}, {29'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic wait_start(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk);
      if (m_start) ok = 1'b1;
      n++;
    end
    if (!ok) check_eq("start_timeout", 32'd0, 32'd1);
    else begin
      cap_gnt = gnt; cap_addr = m_addr; cap_rw = m_rw; cap_wdata = m_wdata;
    end
  endtask

  // Called at the negedge where m_start is visible; m_done is sampled dly edges later.
  task automatic reply(input int dly, input logic nack, input logic [7:0] rd);
    repeat (dly - 1) @(negedge clk);
    m_done = 1'b1; m_nack = nack; m_rdata = rd;
    @(negedge clk);
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'd0;
  endtask

  task automatic master_reply(input int dly, input logic nack, input logic [7:0] rd);
    bit ok;
    wait_start(ok);
    if (ok) reply(dly, nack, rd);
  endtask

  initial begin
    int n, s0;
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", {30'd0, gnt}, 32'd0);
    check_eq("rst_mstart", {31'd0, m_start}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    check_eq("rst_maddr", {25'd0, m_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single write from requester 0, latency and command fields
    req = 2'b01; req_addr = {7'h00, 7'h39}; req_wdata = {8'h00, 8'hCA}; req_rw = 2'b00;
    @(negedge clk);
    check_eq("t1_gnt", {30'd0, gnt}, 32'h1);
    check_eq("t1_mstart_early", {31'd0, m_start}, 32'd0);
    @(negedge clk);
    check_eq("t1_mstart", {31'd0, m_start}, 32'd1);
    check_eq("t1_maddr", {25'd0, m_addr}, 32'h39);
    check_eq("t1_mwdata", {24'd0, m_wdata}, 32'hCA);
    check_eq("t1_mrw", {31'd0, m_rw}, 32'd0);
    req = 2'b00;  // dropped mid-transaction: must still complete
    exp_q.push_back(3'b001);
    @(negedge clk);
    check_eq("t1_mstart_1cyc", {31'd0, m_start}, 32'd0);
    reply(19, 1'b0, 8'h00);
    check_eq("t1_done", {30'd0, done}, 32'h1);
    check_eq("t1_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check_eq("t1_done_clr", {30'd0, done}, 32'd0);
    check_eq("t1_gnt_clr", {30'd0, gnt}, 32'd0);

    // m_done outside WAIT is ignored
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("stray_mdone_state", {30'd0, dbg_state}, 32'd0);

    // both requesting: alternate grants starting from ptr=0, m_busy stalls ISSUE
    do_reset();
    m_busy = 1'b1;
    req = 2'b11; req_addr = {7'h50, 7'h21}; req_wdata = {8'h11, 8'h22};
    repeat (5) @(negedge clk);
    check_eq("busy_hold_mstart", {31'd0, m_start}, 32'd0);
    check_eq("busy_hold_state", {30'd0, dbg_state}, 32'd1);
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, exp_seq[i]});
      master_reply(3, 1'b0, 8'h00);
      check_eq("rr_gnt", {30'd0, cap_gnt}, {30'd0, exp_seq[i]});
      check_eq("rr_addr", {25'd0, cap_addr}, exp_seq[i][1] ? 32'h50 : 32'h21);
      if (i == 3) req = 2'b00;
    end
    repeat (3) @(negedge clk);

    // read from requester 1
    req = 2'b10; req_rw = 2'b10; req_addr = {7'h2A, 7'h00};
    exp_q.push_back(3'b010);
    master_reply(5, 1'b0, 8'hA5);
    req = 2'b00;
    check_eq("rd_rw", {31'd0, cap_rw}, 32'd1);
    check_eq("rd_done", {30'd0, done}, 32'h2);
    check_eq("rd_err", {31'd0, err}, 32'd0);
    check_eq("rd_rdata", {24'd0, rdata}, 32'hA5);

    // a write must leave rdata untouched
    repeat (2) @(negedge clk);
    req = 2'b01; req_rw = 2'b00; req_wdata = {8'h00, 8'h77};
    exp_q.push_back(3'b001);
    master_reply(2, 1'b0, 8'h3C);
    req = 2'b00;
    check_eq("wr_rdata_keep", {24'd0, rdata}, 32'hA5);
    check_eq("wr_mwdata", {24'd0, cap_wdata}, 32'h77);

    // NACK on every attempt, twice (retry count must clear per grant)
    for (int r = 0; r < 2; r++) begin
      repeat (3) @(negedge clk);
      s0 = start_cnt;
      req = 2'b01;
      exp_q.push_back(3'b101);
      for (int a = 0; a < 3; a++) begin
        master_reply(2, 1'b1, 8'h00);
        req = 2'b00;
        if (a < 2) check_eq("nack_no_done", {30'd0, done}, 32'd0);
      end
      check_eq("nack_done", {30'd0, done}, 32'h1);
      check_eq("nack_err", {31'd0, err}, 32'd1);
      repeat (3) @(negedge clk);
      check_eq("nack_starts", start_cnt - s0, 32'd3);
    end

    // timeout: done/err exactly 1023 cycles after m_start
    begin
      bit ok;
      req = 2'b01;
      exp_q.push_back(3'b101);
      wait_start(ok);
      req = 2'b00;
      n = 0;
      while (n < 1100 && done == 2'b00) begin
        @(negedge clk);
        n++;
      end
      check_eq("tmo_cycles", n, 32'd1023);
      check_eq("tmo_err", {31'd0, err}, 32'd1);
    end

    // completion on the timeout cycle wins
    repeat (3) @(negedge clk);
    req = 2'b01;
    exp_q.push_back(3'b001);
    master_reply(1023, 1'b0, 8'h00);
    req = 2'b00;
    check_eq("tmo_edge_done", {30'd0, done}, 32'h1);
    check_eq("tmo_edge_err", {31'd0, err}, 32'd0);

    // async reset in WAIT, then a fresh request from requester 1
    begin
      bit ok;
      repeat (3) @(negedge clk);
      req = 2'b01;
      wait_start(ok);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_gnt", {30'd0, gnt}, 32'd0);
      check_eq("arst_mstart", {31'd0, m_start}, 32'd0);
      check_eq("arst_rdata", {24'd0, rdata}, 32'd0);
      check_eq("arst_maddr", {25'd0, m_addr}, 32'd0);
      check_eq("arst_state", {30'd0, dbg_state}, 32'd0);
      req = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("arst_idle", {30'd0, dbg_state}, 32'd0);
      req = 2'b10; req_addr = {7'h44, 7'h00};
      exp_q.push_back(3'b010);
      master_reply(4, 1'b0, 8'h00);
      req = 2'b00;
      check_eq("arst_regnt", {30'd0, cap_gnt}, 32'h2);
      check_eq("arst_done", {30'd0, done}, 32'h2);
    end

    repeat (4) @(negedge clk);
    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
